// File: rtl/reg_file_pkg.sv
// Shared types and default widths for the parameterised register file.
package reg_file_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } rf_state_e;
endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, looked up per read port.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_50,
  input  logic                     rst_i,
  input  logic                     ready,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        byp_hit,
  output logic [NUM_RD-1:0]        rd_busy
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;

  // Set is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (ready) begin
      if (clr_en) busy_d[clr_addr] = 1'b0;
      if (set_en) busy_d[set_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_50 or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    assign rd_busy[i] = ready && busy_q[rd_addr[i*ADDR_W +: ADDR_W]] && !byp_hit[i];
  end
endmodule

// File: rtl/reg_file_param.sv
// Multi-read-port register file with zero-sweep init, write bypass and busy scoreboard.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk_50,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     ld_en,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  output logic                     ready
);
  localparam int DEPTH = 2**ADDR_W;

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [NUM_RD-1:0] byp_hit;
  logic              wr_ok, ld_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = READY;
    end
  end

  always_ff @(posedge clk_50 or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready = (state_q == READY);
  assign wr_ok = ready && we    && !(ZERO_REG != 0 && wa == '0);
  assign ld_ok = ready && ld_en && !(ZERO_REG != 0 && ld_addr == '0);

  // Storage is cleared only by the sweep; the main port is applied last so it wins a tie.
  always_comb begin
    mem_d = mem_q;
    if (!ready) begin
      mem_d[cnt_q] = '0;
    end else begin
      if (ld_ok) mem_d[ld_addr] = ld_data;
      if (wr_ok) mem_d[wa]      = wd;
    end
  end

  always_ff @(posedge clk_50) begin
    mem_q <= mem_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic              hit;

    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rdat = '0;
      hit  = 1'b0;
      if (!ready || (ZERO_REG != 0 && ra == '0)) begin
        rdat = '0;
      end else if (BYPASS != 0 && we && wa == ra) begin
        rdat = wd;
        hit  = 1'b1;
      end else begin
        rdat = mem_q[ra];
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = rdat;
    assign byp_hit[i] = hit;
  end

  reg_file_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk_50  (clk_50),
    .rst_i   (rst_i),
    .ready   (ready),
    .set_en  (busy_set),
    .set_addr(busy_addr),
    .clr_en  (we),
    .clr_addr(wa),
    .rd_addr (rd_addr),
    .byp_hit (byp_hit),
    .rd_busy (rd_busy)
  );
endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param at default parameters (32x32, two read ports).
module tb_reg_file_param;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk_50 = 1'b0;
  logic                     rst_i;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we;
  logic [ADDR_W-1:0]        wa;
  logic [DATA_W-1:0]        wd;
  logic                     ld_en;
  logic [ADDR_W-1:0]        ld_addr;
  logic [DATA_W-1:0]        ld_data;
  logic                     busy_set;
  logic [ADDR_W-1:0]        busy_addr;
  logic                     ready;

  int checks   = 0;
  int failures = 0;
  int init_bad = 0;
  int n;

  reg_file_param dut (
    .clk_50   (clk_50),
    .rst_i    (rst_i),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .busy_set (busy_set),
    .busy_addr(busy_addr),
    .ready    (ready)
  );

  always #10 clk_50 = ~clk_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    busy_set = 1'b0; busy_addr = '0;
  endtask

  task automatic step();
    @(posedge clk_50);
    @(negedge clk_50);
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Counts rising edges until ready; inputs left active during the sweep must be ignored.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!ready && cyc < 100) begin
      @(posedge clk_50);
      #1;
      cyc++;
      if (ready) idle();
      else if (rd_data != '0 || rd_busy != '0) init_bad++;
    end
    @(negedge clk_50);
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    set_rd(5'd5, 5'd6);
    @(negedge clk_50);
    @(negedge clk_50);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rd_data0", rd_data[31:0], 32'd0);
    check("reset_rd_busy", {30'd0, rd_busy}, 32'd0);

    // Release with writes, preloads and busy marks held active through INIT.
    we = 1'b1; wa = 5'd5; wd = 32'h1111;
    ld_en = 1'b1; ld_addr = 5'd8; ld_data = 32'h2222;
    busy_set = 1'b1; busy_addr = 5'd6;
    rst_i = 1'b0;
    wait_ready(n);
    check("init_cycles", n, 32'd32);
    check("init_outputs_zero", init_bad, 32'd0);
    #1;
    check("init_we_ignored", rd_data[31:0], 32'd0);
    check("init_busy_ignored", {31'd0, rd_busy[1]}, 32'd0);
    set_rd(5'd5, 5'd8);
    #1;
    check("init_ld_ignored", rd_data[63:32], 32'd0);

    // Same-cycle bypass, then readback from storage.
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    #1;
    check("bypass_rd0", rd_data[31:0], 32'hDEADBEEF);
    step();
    idle();
    #1;
    check("stored_rd0", rd_data[31:0], 32'hDEADBEEF);

    // Zero register.
    set_rd(5'd0, 5'd0);
    we = 1'b1; wa = 5'd0; wd = 32'h1234;
    #1;
    check("zero_reg_bypass", rd_data[31:0], 32'd0);
    step();
    idle();
    busy_set = 1'b1; busy_addr = 5'd0;
    #1;
    check("zero_reg_stored", rd_data[31:0], 32'd0);
    step();
    idle();
    #1;
    check("zero_reg_busy", {31'd0, rd_busy[1]}, 32'd0);

    // Busy set, held, then cleared by the producing write.
    busy_set = 1'b1; busy_addr = 5'd7;
    step();
    idle();
    set_rd(5'd0, 5'd7);
    #1;
    check("busy7_set", {31'd0, rd_busy[1]}, 32'd1);
    step();
    #1;
    check("busy7_held", {31'd0, rd_busy[1]}, 32'd1);
    we = 1'b1; wa = 5'd7; wd = 32'h55;
    #1;
    check("busy7_write_cycle", {31'd0, rd_busy[1]}, 32'd0);
    check("busy7_bypass_data", rd_data[63:32], 32'h55);
    step();
    idle();
    #1;
    check("busy7_after", {31'd0, rd_busy[1]}, 32'd0);
    check("busy7_stored", rd_data[63:32], 32'h55);

    // Simultaneous set and clear of one register leaves it busy; ld_en never clears.
    busy_set = 1'b1; busy_addr = 5'd10;
    we = 1'b1; wa = 5'd10; wd = 32'h10;
    step();
    idle();
    busy_set = 1'b1; busy_addr = 5'd11;
    step();
    idle();
    ld_en = 1'b1; ld_addr = 5'd11; ld_data = 32'h99;
    step();
    idle();
    set_rd(5'd10, 5'd11);
    #1;
    check("set_beats_clear", {31'd0, rd_busy[0]}, 32'd1);
    check("ld_keeps_busy", {31'd0, rd_busy[1]}, 32'd1);
    check("ld_written", rd_data[63:32], 32'h99);

    // Write-port collision and independent dual writes.
    we = 1'b1; wa = 5'd3; wd = 32'hAAAA;
    ld_en = 1'b1; ld_addr = 5'd3; ld_data = 32'hBBBB;
    step();
    idle();
    set_rd(5'd3, 5'd4);
    #1;
    check("collide_we_wins", rd_data[31:0], 32'hAAAA);
    we = 1'b1; wa = 5'd3; wd = 32'hCCCC;
    ld_en = 1'b1; ld_addr = 5'd4; ld_data = 32'hBBBB;
    step();
    idle();
    #1;
    check("dual_mem3", rd_data[31:0], 32'hCCCC);
    check("dual_mem4", rd_data[63:32], 32'hBBBB);

    // Reset mid-READY restarts the sweep and clears the scoreboard.
    we = 1'b1; wa = 5'd9; wd = 32'h77;
    step();
    idle();
    set_rd(5'd9, 5'd10);
    #1;
    check("pre_reset_mem9", rd_data[31:0], 32'h77);
    rst_i = 1'b1;
    #1;
    check("async_ready_low", {31'd0, ready}, 32'd0);
    check("async_busy_clear", {30'd0, rd_busy}, 32'd0);
    check("async_rd_zero", rd_data[31:0], 32'd0);
    @(negedge clk_50);
    rst_i = 1'b0;
    init_bad = 0;
    wait_ready(n);
    check("reinit_cycles", n, 32'd32);
    check("reinit_outputs_zero", init_bad, 32'd0);
    #1;
    check("reinit_mem9", rd_data[31:0], 32'd0);
    check("reinit_busy10", {31'd0, rd_busy[1]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, when 1 entry 0 SHALL read as 0 and ignore writes.
REQ-005 Parameter BYPASS, default 1, when 1 a same-cycle write SHALL forward to read ports.
REQ-006 clk_50  in  1  system clock, all state on rising edge.
REQ-007 rst_i  in  1  reset, asynchronous, active-high.
REQ-008 rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-009 rd_data  out  NUM_RD*DATA_W  read data, same packing as rd_addr.
REQ-010 rd_busy  out  NUM_RD  scoreboard busy flag per read port.
REQ-011 we / wa / wd  in  1 / ADDR_W / DATA_W  main write enable, address, data.
REQ-012 ld_en / ld_addr / ld_data  in  1 / ADDR_W / DATA_W  preload (debug) write port.
REQ-013 busy_set / busy_addr  in  1 / ADDR_W  mark destination register as pending.
REQ-014 ready  out  1  high once the init sweep is complete.

Function
REQ-015 FSM states: INIT, READY; reset enters INIT with sweep counter at 0.
REQ-016 INIT: one entry per cycle written with 0 at the counter address; counter increments; DEPTH cycles after rst_i falls, state -> READY and ready=1.
REQ-017 In INIT: we, ld_en and busy_set are ignored; all rd_data=0; all rd_busy=0.
REQ-018 READY: we=1 writes wd to mem[wa] at the clock edge; ld_en=1 writes ld_data to mem[ld_addr] on the same edge.
REQ-019 we and ld_en to the same address in the same cycle: wd SHALL win; different addresses: both written.
REQ-020 ZERO_REG=1: writes to address 0 dropped on both ports; rd_data for address 0 always 0; busy[0] always 0.
REQ-021 Reads combinational, zero latency; priority: zero-reg rule, then bypass (BYPASS=1, ready, we, wa==rd_addr -> wd), then storage.
REQ-022 BYPASS=0: written value visible on rd_data the cycle after the write edge.
REQ-023 Scoreboard: busy_set in READY sets busy[busy_addr]; we in READY clears busy[wa]; ld_en does not affect busy.
REQ-024 busy_set and we to the same address in one cycle: busy SHALL end set (new producer wins).
REQ-025 rd_busy[i] = busy[rd_addr[i]], forced 0 when a bypass hit occurs on port i that cycle.
REQ-026 No address is out of range (DEPTH = 2**ADDR_W); no error output.

Reset
REQ-027 rst_i asserted asynchronously: state=INIT, counter=0, ready=0, all busy bits 0, effective immediately.
REQ-028 Storage contents are not reset directly; they are zeroed by the INIT sweep.
REQ-029 Reset during INIT or READY restarts the full DEPTH-cycle sweep; partial prior contents are never readable.

Structure
REQ-030 Package reg_file_pkg SHALL hold the state enum (INIT, READY) and default DATA_W/ADDR_W constants.
REQ-031 Scoreboard SHALL be a sub-module reg_file_scoreboard (busy vector, set/clear, per-port lookup).
REQ-032 Storage SHALL be a flop array indexed by address; no vendor RAM macros.

Verification
REQ-033 Reset, release, count cycles -> ready rises exactly 32 cycles after rst_i falls (defaults); all rd_data=0 before.
REQ-034 READY, we=1 wa=5 wd=0xDEADBEEF, rd_addr port0=5 same cycle -> rd_data0=0xDEADBEEF (bypass); next cycle still 0xDEADBEEF from storage.
REQ-035 we wa=0 wd=0x1234 -> rd_data for address 0 remains 0; rd_busy for address 0 stays 0 after busy_set addr 0.
REQ-036 busy_set addr 7, then we wa=7 wd=0x55 two cycles later -> rd_busy=1 for address 7 in between, 0 in the write cycle (bypass) and after.
REQ-037 we wa=3 wd=0xAAAA and ld_en ld_addr=3 ld_data=0xBBBB same edge -> mem[3]=0xAAAA; ld_addr=4 instead -> mem[3]=0xAAAA, mem[4]=0xBBBB.
REQ-038 Assert rst_i mid-READY with mem[9]=0x77 -> ready=0 immediately; after 32 cycles ready=1 and mem[9] reads 0.
